// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD types, field limits and 12 h mapping for the time-of-day counter
package clock_pkg;

  // Two BCD digits packed as {tens, units}
  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;
  localparam bcd2_t HR_MAX  = 8'h23;
  localparam bcd2_t HR_NOON = 8'h12;

  // Map a 24 h BCD hour (00-23) onto the 12 h dial (01-12); midnight reads 12
  function automatic bcd2_t hr24_to_12(input bcd2_t hr);
    logic [4:0] bin;
    logic [4:0] h12;
    bcd2_t      res;
    bin = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    if (bin == 5'd0) begin
      h12 = 5'd12;
    end else if (bin > 5'd12) begin
      h12 = bin - 5'd12;
    end else begin
      h12 = bin;
    end
    if (h12 >= 5'd10) begin
      res = {4'd1, 4'(h12 - 5'd10)};
    end else begin
      res = {4'd0, h12[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter (00..MAX) with up/down stepping
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,   // chained step from the cascade; its wrap is reported
  input  logic  dec,   // direct adjust step; wraps silently inside the field
  input  logic  down,  // direction for either kind of step
  output bcd2_t q,
  output logic  wrap   // carry (up from MAX) or borrow (down from 00) of a chained step
);

  bcd2_t q_q;
  bcd2_t q_d;
  bcd2_t step_val;
  logic  at_edge;

  // Next BCD value one step away in the selected direction, and the boundary flag
  always_comb begin
    step_val = q_q;
    at_edge  = 1'b0;
    if (down) begin
      at_edge = (q_q == 8'h00);
      if (q_q == 8'h00) begin
        step_val = MAX;
      end else if (q_q[3:0] == 4'd0) begin
        step_val = {q_q[7:4] - 4'd1, 4'd9};
      end else begin
        step_val = {q_q[7:4], q_q[3:0] - 4'd1};
      end
    end else begin
      at_edge = (q_q == MAX);
      if (q_q == MAX) begin
        step_val = 8'h00;
      end else if (q_q[3:0] == 4'd9) begin
        step_val = {q_q[7:4] + 4'd1, 4'd0};
      end else begin
        step_val = {q_q[7:4], q_q[3:0] + 4'd1};
      end
    end
    q_d  = (inc | dec) ? step_val : q_q;
    wrap = inc & at_edge;
  end

  // Field register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/clock_hms_rco.sv
// rtl/clock_hms_rco.sv - prescaled BCD hh:mm:ss counter with up/down, pause, set and 12/24 h display
module clock_hms_rco
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic  mclk,
  input  logic  reset,
  input  logic  enable,
  input  logic  down,
  input  logic  mode_12h,
  input  logic  set_min,
  input  logic  set_hr,
  output bcd2_t sec_bcd,
  output bcd2_t min_bcd,
  output bcd2_t hr_bcd,
  output logic  pm,
  output logic  tick,
  output logic  day_rco
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("clock_hms_rco: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             day_rco_q, day_rco_d;
  logic             set_any;
  logic             chain_step;
  logic             sec_wrap, min_wrap, hr_wrap;
  bcd2_t            sec_int, min_int, hr_int;

  // Prescaler: count 0..DIV-1 while enabled; the wrap raises tick for one cycle
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // A set request owns the chain for that cycle, so a coincident tick is dropped
  always_comb begin
    set_any    = set_min | set_hr;
    chain_step = tick_q & ~set_any;
    day_rco_d  = hr_wrap;
  end

  // Prescaler, tick and day pulse registers
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      day_rco_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      day_rco_q <= day_rco_d;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk  (mclk),
    .rst  (reset),
    .inc  (chain_step),
    .dec  (1'b0),
    .down (down),
    .q    (sec_int),
    .wrap (sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (mclk),
    .rst  (reset),
    .inc  (sec_wrap),
    .dec  (set_min),
    .down (down),
    .q    (min_int),
    .wrap (min_wrap)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk  (mclk),
    .rst  (reset),
    .inc  (min_wrap),
    .dec  (set_hr),
    .down (down),
    .q    (hr_int),
    .wrap (hr_wrap)
  );

  // Display mapping follows mode_12h combinationally; internal hour stays 24 h
  always_comb begin
    hr_bcd = mode_12h ? hr24_to_12(hr_int) : hr_int;
    pm     = (hr_int >= HR_NOON);
  end

  assign sec_bcd = sec_int;
  assign min_bcd = min_int;
  assign tick    = tick_q;
  assign day_rco = day_rco_q;

endmodule

// File: tb/tb_clock_hms_rco.sv
// tb/tb_clock_hms_rco.sv - scoreboard bench for clock_hms_rco against a seconds-of-day model
module tb_clock_hms_rco;

  localparam int DIV = 10;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       down = 1'b0;
  logic       mode_12h = 1'b0;
  logic       set_min = 1'b0;
  logic       set_hr = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       pm, tick, day_rco;

  always #5 mclk = ~mclk;

  clock_hms_rco #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .mclk     (mclk),
    .reset    (reset),
    .enable   (enable),
    .down     (down),
    .mode_12h (mode_12h),
    .set_min  (set_min),
    .set_hr   (set_hr),
    .sec_bcd  (sec_bcd),
    .min_bcd  (min_bcd),
    .hr_bcd   (hr_bcd),
    .pm       (pm),
    .tick     (tick),
    .day_rco  (day_rco)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] m;
    logic [7:0] h;
    logic       pm;
    logic       tick;
    logic       rco;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: time of day as seconds since midnight, prescaler as a plain count
  int m_cnt;
  int m_t;
  bit m_tick;
  bit m_rco;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic obs_t model_view(input bit m12);
    obs_t o;
    int h, hd;
    h = m_t / 3600;
    hd = m12 ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    o.s    = to_bcd(m_t % 60);
    o.m    = to_bcd((m_t / 60) % 60);
    o.h    = to_bcd(hd);
    o.pm   = (h >= 12);
    o.tick = m_tick;
    o.rco  = m_rco;
    return o;
  endfunction

  function automatic obs_t dut_view();
    obs_t o;
    o.s    = sec_bcd;
    o.m    = min_bcd;
    o.h    = hr_bcd;
    o.pm   = pm;
    o.tick = tick;
    o.rco  = day_rco;
    return o;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_t    = 0;
    m_tick = 0;
    m_rco  = 0;
  endtask

  task automatic model_step(input bit en, input bit dn, input bit sm, input bit sh);
    int h, mi, s, nt;
    bit nrco;
    h    = m_t / 3600;
    mi   = (m_t / 60) % 60;
    s    = m_t % 60;
    nt   = m_t;
    nrco = 0;
    if (sm || sh) begin
      if (sm) mi = (mi + (dn ? 59 : 1)) % 60;
      if (sh) h = (h + (dn ? 23 : 1)) % 24;
      nt = h * 3600 + mi * 60 + s;
    end else if (m_tick) begin
      nt   = (m_t + (dn ? 86399 : 1)) % 86400;
      nrco = dn ? (m_t == 0) : (m_t == 86399);
    end
    m_t    = nt;
    m_rco  = nrco;
    m_tick = en && (m_cnt == DIV - 1);
    if (en) m_cnt = (m_cnt + 1) % DIV;
  endtask

  task automatic check(input string nm, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got s=%h m=%h h=%h pm=%b tick=%b rco=%b, want s=%h m=%h h=%h pm=%b tick=%b rco=%b",
               nm, $time, got.s, got.m, got.h, got.pm, got.tick, got.rco,
               want.s, want.m, want.h, want.pm, want.tick, want.rco);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, predict the state after the next rising edge
  task automatic cyc(input bit en, input bit dn, input bit m12, input bit sm, input bit sh, input bit rst);
    bit mode_changed, rst_rise;
    @(negedge mclk);
    mode_changed = (m12 != mode_12h);
    rst_rise     = rst && !reset;
    enable   = en;
    down     = dn;
    mode_12h = m12;
    set_min  = sm;
    set_hr   = sh;
    reset    = rst;
    if (rst) model_reset();
    if (mode_changed || rst_rise) begin
      #1;
      check(rst_rise ? "async_reset" : "mode_toggle", dut_view(), model_view(m12));
    end
    if (rst) model_reset();
    else model_step(en, dn, sm, sh);
    exp_q.push_back(model_view(m12));
  endtask

  task automatic run(input int n, input bit en, input bit dn, input bit m12);
    for (int i = 0; i < n; i++) cyc(en, dn, m12, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a new state shortly after the rising edge
  initial begin
    forever begin
      @(posedge mclk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("scoreboard", dut_view(), mon_e);
      end
    end
  end

  initial begin
    bit en, dn, m12, sm, sh, rs;
    int guard;
    model_reset();

    // Reset state in both display modes, then free run
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    run(25, 1, 0, 0);

    // Pause at prescaler count 5, then a reset pulse mid-count
    guard = 0;
    while (m_cnt != 5 && guard < 2 * DIV) begin
      cyc(1, 0, 0, 0, 0, 0);
      guard++;
    end
    run(20, 0, 0, 0);
    run(3, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);

    // Down wrap from midnight, then up wrap back through midnight
    run(15, 1, 1, 0);
    run(25, 1, 0, 0);

    // Set hours to 10 while paused, then borrow down to 09:59:59
    cyc(0, 0, 0, 0, 0, 1);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    run(15, 1, 1, 0);

    // Set priority over a coincident tick around 00:59:30
    cyc(0, 0, 0, 0, 0, 1);
    run(305, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    guard = 0;
    while (!m_tick && guard < 2 * DIV) begin
      cyc(1, 0, 0, 0, 0, 0);
      guard++;
    end
    repeat (3) cyc(1, 0, 0, 1, 0, 0);
    run(3, 1, 0, 0);

    // 12 h display at hour 13 and 12, toggling the mode
    cyc(0, 0, 1, 0, 0, 1);
    repeat (13) cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);

    // Randomized traffic
    dn  = 0;
    m12 = 0;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) dn = ~dn;
      if ($urandom_range(0, 29) == 0) m12 = ~m12;
      sm = ($urandom_range(0, 14) == 0);
      sh = ($urandom_range(0, 14) == 0);
      rs = ($urandom_range(0, 399) == 0);
      cyc(en, dn, m12, sm, sh, rs);
    end

    run(2, 0, 0, 0);
    @(negedge mclk);
    @(negedge mclk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
